// File: rtl/regfile_wport_arbiter.sv
// Register-file write-port arbiter.
// Two writers share the single regfile write port: the in-order writeback
// stage (WB) and a long-latency unit (LU) whose results are queued in a
// small FIFO. WB normally wins; a starvation counter eventually forces the
// FIFO head through by stalling WB. A scoreboard of in-flight LU
// destinations lets decode detect RAW hazards on those registers.
module regfile_wport_arbiter #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // writeback writer
  input  logic [4:0]  wb_wa,
  input  logic [3:0]  wb_we,
  input  logic [31:0] wb_wd,
  output logic        wb_stall,
  // long-latency unit result channel
  input  logic        lu_valid,
  output logic        lu_ready,
  input  logic [4:0]  lu_wa,
  input  logic [31:0] lu_wd,
  // issue / decode side
  input  logic        iss_valid,
  input  logic [4:0]  iss_wa,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        busy1,
  output logic        busy2,
  // regfile write port
  output logic [4:0]  rf_wa,
  output logic [3:0]  rf_we,
  output logic [31:0] rf_wd
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = AW + 1;
  localparam int CW = $clog2(STARVE_LIMIT + 1);

  // FIFO state: pointers carry an extra wrap bit so full and empty differ
  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [4:0]    mem_wa_q [DEPTH];
  logic [4:0]    mem_wa_d [DEPTH];
  logic [31:0]   mem_wd_q [DEPTH];
  logic [31:0]   mem_wd_d [DEPTH];

  // cycles the current non-empty head has lost to WB
  logic [CW-1:0] cnt_q, cnt_d;

  // bit 0 is kept at zero so r0 never reads as busy
  logic [31:0]   sb_q, sb_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          starved;
  logic          wb_active;
  logic [4:0]    head_wa;
  logic [31:0]   head_wd;

  // FIFO status, handshake and arbitration decision
  always_comb begin
    full      = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    empty     = (wp_q == rp_q);
    head_wa   = mem_wa_q[rp_q[AW-1:0]];
    head_wd   = mem_wd_q[rp_q[AW-1:0]];
    wb_active = (wb_we != 4'b0000);
    starved   = !empty && (cnt_q == CW'(STARVE_LIMIT));
    // lu_ready depends only on registered state, never on lu_valid
    push      = lu_valid && !full && !reset;
    pop       = !empty && (starved || !wb_active) && !reset;
  end

  // write-port mux and status outputs, all forced quiet while in reset
  always_comb begin
    wb_stall = 1'b0;
    lu_ready = 1'b0;
    busy1    = 1'b0;
    busy2    = 1'b0;
    rf_wa    = 5'd0;
    rf_we    = 4'b0000;
    rf_wd    = 32'd0;
    if (!reset) begin
      wb_stall = starved;
      lu_ready = !full;
      busy1    = (ra1 != 5'd0) && sb_q[ra1];
      busy2    = (ra2 != 5'd0) && sb_q[ra2];
      if (pop) begin
        rf_wa = head_wa;
        rf_wd = head_wd;
        // a result for r0 still drains, it just never writes
        rf_we = (head_wa != 5'd0) ? 4'b1111 : 4'b0000;
      end else begin
        rf_wa = wb_wa;
        rf_wd = wb_wd;
        rf_we = wb_we;
      end
    end
  end

  // next FIFO contents and pointers
  always_comb begin
    wp_d     = wp_q;
    rp_d     = rp_q;
    mem_wa_d = mem_wa_q;
    mem_wd_d = mem_wd_q;
    if (push) begin
      mem_wa_d[wp_q[AW-1:0]] = lu_wa;
      mem_wd_d[wp_q[AW-1:0]] = lu_wd;
      wp_d                   = wp_q + PW'(1);
    end
    if (pop) begin
      rp_d = rp_q + PW'(1);
    end
  end

  // starvation counter: counts WB wins over a waiting head, cleared on any pop
  always_comb begin
    cnt_d = cnt_q;
    if (empty || pop) begin
      cnt_d = '0;
    end else if (wb_active && (cnt_q != CW'(STARVE_LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // scoreboard: clear on commit first so a same-cycle issue wins
  always_comb begin
    sb_d = sb_q;
    if (pop && (head_wa != 5'd0)) begin
      sb_d[head_wa] = 1'b0;
    end
    if (!reset && iss_valid && (iss_wa != 5'd0)) begin
      sb_d[iss_wa] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // state registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
      sb_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_wa_q[i] <= '0;
        mem_wd_q[i] <= '0;
      end
    end else begin
      wp_q     <= wp_d;
      rp_q     <= rp_d;
      cnt_q    <= cnt_d;
      sb_q     <= sb_d;
      mem_wa_q <= mem_wa_d;
      mem_wd_q <= mem_wd_d;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
module tb_regfile_wport_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  wb_wa = '0;
  logic [3:0]  wb_we = '0;
  logic [31:0] wb_wd = '0;
  logic        wb_stall;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_wa = '0;
  logic [31:0] lu_wd = '0;
  logic        iss_valid = 1'b0;
  logic [4:0]  iss_wa = '0;
  logic [4:0]  ra1 = '0;
  logic [4:0]  ra2 = '0;
  logic        busy1, busy2;
  logic [4:0]  rf_wa;
  logic [3:0]  rf_we;
  logic [31:0] rf_wd;

  int tests = 0;
  int fails = 0;

  regfile_wport_arbiter #(.DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .wb_wa(wb_wa), .wb_we(wb_we), .wb_wd(wb_wd), .wb_stall(wb_stall),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_wa(lu_wa), .lu_wd(lu_wd),
    .iss_valid(iss_valid), .iss_wa(iss_wa), .ra1(ra1), .ra2(ra2),
    .busy1(busy1), .busy2(busy2),
    .rf_wa(rf_wa), .rf_we(rf_we), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [4:0]  wba;
    logic [3:0]  wbwe;
    logic [31:0] wbwd;
    logic        luv;
    logic [4:0]  luwa;
    logic [31:0] luwd;
    logic        issv;
    logic [4:0]  isswa;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic        e_stall;
    logic        e_ready;
    logic        e_b1;
    logic        e_b2;
    logic [3:0]  e_we;
    logic        chk;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic r, input logic [4:0] wba, input logic [3:0] wbwe, input logic [31:0] wbwd,
    input logic luv, input logic [4:0] luwa, input logic [31:0] luwd,
    input logic issv, input logic [4:0] isswa, input logic [4:0] a1, input logic [4:0] a2,
    input logic es, input logic er, input logic eb1, input logic eb2,
    input logic [3:0] ewe, input logic chk, input logic [4:0] ewa, input logic [31:0] ewd);
    vec_t v;
    v.r = r; v.wba = wba; v.wbwe = wbwe; v.wbwd = wbwd;
    v.luv = luv; v.luwa = luwa; v.luwd = luwd;
    v.issv = issv; v.isswa = isswa; v.a1 = a1; v.a2 = a2;
    v.e_stall = es; v.e_ready = er; v.e_b1 = eb1; v.e_b2 = eb2;
    v.e_we = ewe; v.chk = chk; v.e_wa = ewa; v.e_wd = ewd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wb_wa = '0; wb_we = '0; wb_wd = '0;
    lu_valid = 1'b0; lu_wa = '0; lu_wd = '0;
    iss_valid = 1'b0; iss_wa = '0; ra1 = '0; ra2 = '0;
  endtask

  int found;

  initial begin
    //         r  wba   we     wbwd        luv luwa  luwd          iss iwa   a1    a2     st rdy b1 b2 we    chk wa    wd
    // reset held while a result is offered
    vecs.push_back(mk(1, 5'd3, 4'hF, 32'h33,       1, 5'd5,  32'hAAAA,     1, 5'd5, 5'd5, 5'd0,  0, 0, 0, 0, 4'h0, 1, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd5, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    // single LU result on an idle port
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd5, 5'd5, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        1, 5'd5,  32'hDEADBEEF, 0, 5'd0, 5'd5, 5'd0,  0, 1, 1, 0, 4'h0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd5, 5'd0,  0, 1, 1, 0, 4'hF, 1, 5'd5, 32'hDEADBEEF));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd5, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    // WB collision
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        1, 5'd6,  32'h66,       0, 5'd0, 5'd6, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd3, 4'hF, 32'h11,       0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd3, 32'h11));
    vecs.push_back(mk(0, 5'd3, 4'hF, 32'h11,       0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd3, 32'h11));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd6, 32'h66));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    // starvation: head waits 4 WB wins, forced through on the 5th cycle
    vecs.push_back(mk(0, 5'd1, 4'hF, 32'h111,      1, 5'd8,  32'h88,       0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd1, 32'h111));
    vecs.push_back(mk(0, 5'd1, 4'hF, 32'h112,      0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd1, 32'h112));
    vecs.push_back(mk(0, 5'd1, 4'hF, 32'h113,      0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd1, 32'h113));
    vecs.push_back(mk(0, 5'd1, 4'hF, 32'h114,      0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd1, 32'h114));
    vecs.push_back(mk(0, 5'd1, 4'hF, 32'h115,      0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd1, 32'h115));
    vecs.push_back(mk(0, 5'd1, 4'hF, 32'h116,      0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  1, 1, 0, 0, 4'hF, 1, 5'd8, 32'h88));
    vecs.push_back(mk(0, 5'd1, 4'hF, 32'h117,      0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd1, 32'h117));
    // full FIFO, held third result, in-order drain
    vecs.push_back(mk(0, 5'd2, 4'hF, 32'h200,      1, 5'd10, 32'hA0,       1, 5'd10, 5'd0, 5'd10, 0, 1, 0, 0, 4'hF, 1, 5'd2, 32'h200));
    vecs.push_back(mk(0, 5'd2, 4'hF, 32'h201,      1, 5'd11, 32'hB0,       0, 5'd0, 5'd0, 5'd10, 0, 1, 0, 1, 4'hF, 1, 5'd2, 32'h201));
    vecs.push_back(mk(0, 5'd2, 4'hF, 32'h202,      1, 5'd12, 32'hC0,       0, 5'd0, 5'd0, 5'd10, 0, 0, 0, 1, 4'hF, 1, 5'd2, 32'h202));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        1, 5'd12, 32'hC0,       0, 5'd0, 5'd0, 5'd10, 0, 0, 0, 1, 4'hF, 1, 5'd10, 32'hA0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        1, 5'd12, 32'hC0,       0, 5'd0, 5'd0, 5'd10, 0, 1, 0, 0, 4'hF, 1, 5'd11, 32'hB0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd12, 32'hC0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    // r0 result drains without writing
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        1, 5'd0,  32'hBAD,      0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        1, 5'd9,  32'h99,       0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'h0, 1, 5'd0, 32'hBAD));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'hF, 1, 5'd9, 32'h99));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd0, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    // re-issue of r7 in the cycle its previous result commits
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd7, 5'd7, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        1, 5'd7,  32'h77,       0, 5'd0, 5'd7, 5'd0,  0, 1, 1, 0, 4'h0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        1, 5'd7, 5'd7, 5'd0,  0, 1, 1, 0, 4'hF, 1, 5'd7, 32'h77));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd7, 5'd0,  0, 1, 1, 0, 4'h0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        1, 5'd7,  32'h78,       0, 5'd0, 5'd7, 5'd0,  0, 1, 1, 0, 4'h0, 0, 5'd0, 32'h0));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd7, 5'd0,  0, 1, 1, 0, 4'hF, 1, 5'd7, 32'h78));
    vecs.push_back(mk(0, 5'd0, 4'h0, 32'h0,        0, 5'd0,  32'h0,        0, 5'd0, 5'd7, 5'd0,  0, 1, 0, 0, 4'h0, 0, 5'd0, 32'h0));

    foreach (vecs[i]) begin
      @(negedge clk);
      reset = vecs[i].r;
      wb_wa = vecs[i].wba; wb_we = vecs[i].wbwe; wb_wd = vecs[i].wbwd;
      lu_valid = vecs[i].luv; lu_wa = vecs[i].luwa; lu_wd = vecs[i].luwd;
      iss_valid = vecs[i].issv; iss_wa = vecs[i].isswa;
      ra1 = vecs[i].a1; ra2 = vecs[i].a2;
      #1;
      check($sformatf("v%0d.wb_stall", i), 32'(wb_stall), 32'(vecs[i].e_stall));
      check($sformatf("v%0d.lu_ready", i), 32'(lu_ready), 32'(vecs[i].e_ready));
      check($sformatf("v%0d.busy1", i),    32'(busy1),    32'(vecs[i].e_b1));
      check($sformatf("v%0d.busy2", i),    32'(busy2),    32'(vecs[i].e_b2));
      check($sformatf("v%0d.rf_we", i),    32'(rf_we),    32'(vecs[i].e_we));
      if (vecs[i].chk) begin
        check($sformatf("v%0d.rf_wa", i), 32'(rf_wa), 32'(vecs[i].e_wa));
        check($sformatf("v%0d.rf_wd", i), rf_wd, vecs[i].e_wd);
      end
    end

    // async reset in the middle of a cycle with a full FIFO and a busy register
    @(negedge clk);
    drive_idle();
    wb_wa = 5'd2; wb_we = 4'hF; wb_wd = 32'h300;
    lu_valid = 1'b1; lu_wa = 5'd13; lu_wd = 32'hD0;
    iss_valid = 1'b1; iss_wa = 5'd13;
    @(negedge clk);
    iss_valid = 1'b0;
    lu_wa = 5'd14; lu_wd = 32'hE0;
    @(negedge clk);
    lu_valid = 1'b0; ra1 = 5'd13;
    #1;
    check("pre_rst.busy1", 32'(busy1), 32'd1);
    check("pre_rst.lu_ready", 32'(lu_ready), 32'd0);
    #2 reset = 1'b1;
    lu_valid = 1'b1;
    #1;
    check("rst.lu_ready", 32'(lu_ready), 32'd0);
    check("rst.busy1",    32'(busy1),    32'd0);
    check("rst.rf_we",    32'(rf_we),    32'd0);
    check("rst.rf_wa",    32'(rf_wa),    32'd0);
    check("rst.rf_wd",    rf_wd,         32'd0);
    check("rst.wb_stall", 32'(wb_stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    drive_idle();
    ra1 = 5'd13;
    #1;
    check("post_rst.rf_we",    32'(rf_we),    32'd0);
    check("post_rst.lu_ready", 32'(lu_ready), 32'd1);
    check("post_rst.busy1",    32'(busy1),    32'd0);

    // bounded wait for forced commit under continuous WB traffic
    @(negedge clk);
    wb_wa = 5'd4; wb_we = 4'hF; wb_wd = 32'h400;
    lu_valid = 1'b1; lu_wa = 5'd15; lu_wd = 32'hF0;
    found = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      lu_valid = 1'b0;
      wb_wd = 32'h400 + 32'(c);
      #1;
      if (wb_stall) begin
        found = c;
        break;
      end
    end
    if (found == 0) begin
      tests++;
      fails++;
      $display("FAIL starve.timeout: wb_stall never seen within 12 cycles, required by cycle 5");
    end else begin
      check("starve.cycle", 32'(found), 32'd5);
      check("starve.rf_wa", 32'(rf_wa), 32'd15);
      check("starve.rf_wd", rf_wd, 32'hF0);
      @(negedge clk);
      #1;
      check("starve.release", 32'(wb_stall), 32'd0);
      check("starve.wb_wins", 32'(rf_wa), 32'd4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
